// File: rtl/muldiv_ctrl_unit.sv
// rtl/muldiv_ctrl_unit.sv - R-type mult/div/HI-LO decoder with radix-2 iterative datapath
module muldiv_ctrl_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int DW = 2 * WIDTH;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] r_opb;     // mult: multiplicand magnitude; div: divisor magnitude
    logic             r_is_div;
    logic             r_neg_q;   // product / quotient must be negated
    logic             r_neg_r;   // remainder must be negated (dividend was negative)
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_req;
    logic             w_is_md;
    logic             w_accept_md;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed;
    logic             w_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_diff;
    logic [DW-1:0]    w_step;
    logic [DW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Cancel in IDLE suppresses any same-cycle request, including mthi/mtlo.
    assign w_req       = start & (aluop == 2'b10) & (r_state == S_IDLE) & ~cancel;
    assign w_is_md     = (funct[5:2] == 4'b0110);
    assign w_accept_md = w_req & w_is_md;
    assign w_mthi      = w_req & (funct == F_MTHI);
    assign w_mtlo      = w_req & (funct == F_MTLO);

    // Within mult/multu/div/divu: bit0 clear means signed, bit1 set means divide.
    assign w_signed = ~funct[0];
    assign w_div    = funct[1];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag  = w_b_neg ? (~b + WIDTH'(1)) : b;

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_add  = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_shl  = {r_acc[DW-1:WIDTH], r_acc[WIDTH-1]};
        w_diff = w_shl - {1'b0, r_opb};
        if (r_is_div) begin
            if (w_diff[WIDTH]) begin
                w_step = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
                w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_step = {w_add, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the unsigned-magnitude results.
    always_comb begin
        w_prod_fix = r_neg_q ? (~r_acc + DW'(1)) : r_acc;
        w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
        w_rem_fix  = r_neg_r ? (~r_acc[DW-1:WIDTH] + WIDTH'(1)) : r_acc[DW-1:WIDTH];
    end

    // Control FSM and iterative datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_md) begin
                        r_state  <= S_RUN;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_is_div <= w_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= w_div & (b == '0);
                        r_opb    <= w_div ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO plus the completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if (w_mthi) begin
                r_hi <= a;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end
            if ((r_state == S_FIX) && !cancel) begin
                r_done <= 1'b1;
                if (r_is_div) begin
                    r_lo       <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
                    r_hi       <= w_rem_fix;
                    r_div_zero <= r_dz;
                end else begin
                    r_hi <= w_prod_fix[DW-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    // mfhi/mflo read port; shows the committed HI/LO even while busy.
    always_comb begin
        rdata = '0;
        if (funct == F_MFHI) begin
            rdata = r_hi;
        end else if (funct == F_MFLO) begin
            rdata = r_lo;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl_unit.sv
// tb/tb_muldiv_ctrl_unit.sv - self-checking bench for muldiv_ctrl_unit
module tb_muldiv_ctrl_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   aluop  = 2'b00;
    logic [5:0]   funct  = 6'b000000;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .aluop    (aluop),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the instruction semantics.
    function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (f)
            F_MULT:  begin q = sx * sy; {h, l} = q; end
            F_MULTU: begin p = ux * uy; {h, l} = p; end
            default: begin
                if (y == '0) begin
                    l  = '1;
                    h  = x;
                    dz = 1'b1;
                end else if (f == F_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[W-1:0];
                    h = r[W-1:0];
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    // Behavioural model: countdown of remaining busy cycles and pending result.
    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic         m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
        end else begin
            m_idle = (m_left == 0);
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (!m_idle) begin
                if (cancel) begin
                    m_left = 0;
                end else if (m_left == 1) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                    m_dz   = p_dz;
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end else if (start && aluop == 2'b10 && !cancel) begin
                case (funct)
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        ref_op(funct, a, b, p_hi, p_lo, p_dz);
                        m_left = W + 1;
                    end
                    F_MTHI:  m_hi = a;
                    F_MTLO:  m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", busy, m_left != 0);
        chk("done", done, m_done);
        chk("div_zero", div_zero, m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("rdata", rdata, (funct == F_MFHI) ? m_hi : ((funct == F_MFLO) ? m_lo : '0));
    end

    task automatic issue_now(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [1:0] op);
        start = 1'b1;
        funct = f;
        a     = x;
        b     = y;
        aluop = op;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [1:0] op);
        @(negedge clk);
        #1;
        issue_now(f, x, y, op);
    endtask

    task automatic wait_done(output int nb, output logic dz_seen);
        nb      = 0;
        dz_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                dz_seen = div_zero;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_done: no done within 100 cycles, got busy count %0d expected done", nb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   nb;
    logic dzs;
    int   saw_done;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        #1 rst_n = 1'b1;

        issue(F_MULT, 32'hFFFFFFFF, 32'h00000002, 2'b10);
        wait_done(nb, dzs);
        chk("mult_busy_cycles", nb, 33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002, 2'b10);
        wait_done(nb, dzs);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        issue(F_DIV, 32'hFFFFFFF9, 32'h00000002, 2'b10);
        wait_done(nb, dzs);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(F_DIVU, 32'd7, 32'd2, 2'b10);
        wait_done(nb, dzs);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(F_DIVU, 32'h12345678, 32'h0, 2'b10);
        wait_done(nb, dzs);
        chk("divz_busy_cycles", nb, 33);
        chk("divz_flag", dzs, 1'b1);
        chk("divz_lo", lo, 32'hFFFFFFFF);
        chk("divz_hi", hi, 32'h12345678);

        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 2'b10);
        wait_done(nb, dzs);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h0);

        issue(F_DIV, 32'hFFFFFF00, 32'h0, 2'b10);
        wait_done(nb, dzs);
        chk("sdivz_flag", dzs, 1'b1);
        chk("sdivz_lo", lo, 32'hFFFFFFFF);
        chk("sdivz_hi", hi, 32'hFFFFFF00);

        issue(F_MTHI, 32'hCAFEF00D, 32'h0, 2'b10);
        funct = F_MFHI;
        @(negedge clk);
        chk("mfhi_rdata", rdata, 32'hCAFEF00D);
        chk("mthi_busy", busy, 1'b0);

        issue(F_MTLO, 32'd5, 32'h0, 2'b10);
        funct = F_MFLO;
        @(negedge clk);
        chk("mflo_rdata", rdata, 32'd5);
        chk("mtlo_busy", busy, 1'b0);
        chk("mtlo_done", done, 1'b0);

        issue(6'b100000, 32'd1, 32'd2, 2'b10);
        @(negedge clk);
        chk("unknown_funct_busy", busy, 1'b0);

        // Cancel mid-multiply; stray starts while busy must be dropped.
        issue(F_MULT, 32'd3, 32'd5, 2'b10);
        repeat (3) @(negedge clk);
        #1 issue_now(F_DIVU, 32'd9, 32'd9, 2'b00);
        @(negedge clk);
        #1 issue_now(F_MTHI, 32'h1111, 32'h0, 2'b10);
        repeat (4) @(negedge clk);
        chk("pre_cancel_busy", busy, 1'b1);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_hi", hi, 32'hCAFEF00D);
        chk("cancel_lo", lo, 32'd5);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("cancel_no_done", saw_done, 0);

        // Cancel in IDLE beats a same-cycle mthi.
        @(negedge clk);
        #1 cancel = 1'b1;
        issue_now(F_MTHI, 32'h2222, 32'h0, 2'b10);
        cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_hi", hi, 32'hCAFEF00D);

        // Back-to-back: new op accepted in the done cycle.
        issue(F_DIVU, 32'd100, 32'd7, 2'b10);
        wait_done(nb, dzs);
        chk("b2b1_lo", lo, 32'd14);
        chk("b2b1_hi", hi, 32'd2);
        #1 issue_now(F_MULTU, 32'd6, 32'd7, 2'b10);
        wait_done(nb, dzs);
        chk("b2b2_busy_cycles", nb, 33);
        chk("b2b2_hi", hi, 32'd0);
        chk("b2b2_lo", lo, 32'd42);

        // Asynchronous reset in the middle of a divide.
        issue(F_DIV, 32'd100, 32'd3, 2'b10);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("arst_no_done", saw_done, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
